regfile_writeback: RTL and testbench

Writeback stage of the RV32I core. It is the write-side master for the 32-entry register file. It accepts results from the ALU path and the load path over valid/ready handshakes, and sign/zero-extends load data. It arbitrates between the two sources and drives a registered single write port. It also keeps a pending-load scoreboard, which the decode/hazard logic reads.

---
 rtl/regfile_writeback.sv | 127 ++++++++++++
 tb/tb_regfile_writeback.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: RV32I writeback stage.
// Merges ALU results and load responses onto the single registered register
// file write port, extends load data, and tracks a pending-load scoreboard.
// Optional: define WB_RR_ARB_EN for round-robin load/ALU arbitration;
// without it the load path always wins a conflict.
module regfile_writeback #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_alu_valid,
    output logic                       o_alu_ready,
    input  logic [ADDR_WIDTH-1:0]      i_alu_rd,
    input  logic [DATA_WIDTH-1:0]      i_alu_data,
    input  logic                       i_ld_valid,
    output logic                       o_ld_ready,
    input  logic [ADDR_WIDTH-1:0]      i_ld_rd,
    input  logic [DATA_WIDTH-1:0]      i_ld_data,
    input  logic [2:0]                 i_ld_funct3,
    input  logic [1:0]                 i_ld_off,
    input  logic                       i_iss_valid,
    output logic                       o_iss_ready,
    input  logic [ADDR_WIDTH-1:0]      i_iss_rd,
    output logic [(1<<ADDR_WIDTH)-1:0] o_busy,
    output logic                       o_we,
    output logic [ADDR_WIDTH-1:0]      o_wr_address,
    output logic [DATA_WIDTH-1:0]      o_wr_data,
    output logic                       o_ld_err
);
    localparam int NREG = 1 << ADDR_WIDTH;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic            alu_eligible;
    logic            ld_xfer;
    logic            alu_xfer;
    logic            iss_xfer;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;
    logic            ld_illegal;
    logic [NREG-1:0] busy_next;

    // An ALU write must not overtake a pending load to the same register.
    assign alu_eligible = !(o_busy[i_alu_rd] && (i_alu_rd != '0));

`ifdef WB_RR_ARB_EN
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LD  = 1'b1;
    logic last_grant;

    assign o_ld_ready  = !rst && !(i_alu_valid && alu_eligible && (last_grant == GRANT_LD));
    assign o_alu_ready = !rst && alu_eligible && (!i_ld_valid || (last_grant == GRANT_LD));

    // Remember the most recent winner so the next conflict goes to the other side.
    always_ff @(posedge clk) begin
        if (rst)           last_grant <= GRANT_ALU;
        else if (ld_xfer)  last_grant <= GRANT_LD;
        else if (alu_xfer) last_grant <= GRANT_ALU;
    end
`else
    assign o_ld_ready  = !rst;
    assign o_alu_ready = !rst && !i_ld_valid && alu_eligible;
`endif

    assign o_iss_ready = !rst && ((i_iss_rd == '0) || !o_busy[i_iss_rd]);

    assign ld_xfer  = i_ld_valid  && o_ld_ready;
    assign alu_xfer = i_alu_valid && o_alu_ready;
    assign iss_xfer = i_iss_valid && o_iss_ready;

    // Select and extend the addressed byte/half of the raw load word.
    always_comb begin
        ld_byte    = i_ld_data[8*i_ld_off +: 8];
        ld_half    = i_ld_data[16*i_ld_off[1] +: 16];
        ld_ext     = '0;
        ld_illegal = 1'b0;
        case (i_ld_funct3)
            F3_LB:   ld_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            F3_LH:   ld_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            F3_LHU:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            F3_LW:   ld_ext = i_ld_data;
            default: ld_illegal = 1'b1;
        endcase
    end

    // Completed loads release their register; new issues claim theirs (x0 never busy).
    always_comb begin
        busy_next = o_busy;
        if (ld_xfer)
            busy_next[i_ld_rd] = 1'b0;
        if (iss_xfer && (i_iss_rd != '0))
            busy_next[i_iss_rd] = 1'b1;
    end

    // Registered write port; address/data track every transfer, x0 writes are masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_we         <= 1'b0;
            o_wr_address <= '0;
            o_wr_data    <= '0;
            o_ld_err     <= 1'b0;
            o_busy       <= '0;
        end else begin
            o_busy   <= busy_next;
            o_we     <= 1'b0;
            o_ld_err <= 1'b0;
            if (ld_xfer) begin
                o_we         <= (i_ld_rd != '0);
                o_wr_address <= i_ld_rd;
                o_wr_data    <= ld_ext;
                o_ld_err     <= ld_illegal;
            end else if (alu_xfer) begin
                o_we         <= (i_alu_rd != '0);
                o_wr_address <= i_alu_rd;
                o_wr_data    <= i_alu_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed scenarios plus randomized traffic checked
// against a register-level reference model of the writeback stage.
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_alu_valid = 1'b0;
    logic        o_alu_ready;
    logic [4:0]  i_alu_rd = '0;
    logic [31:0] i_alu_data = '0;
    logic        i_ld_valid = 1'b0;
    logic        o_ld_ready;
    logic [4:0]  i_ld_rd = '0;
    logic [31:0] i_ld_data = '0;
    logic [2:0]  i_ld_funct3 = '0;
    logic [1:0]  i_ld_off = '0;
    logic        i_iss_valid = 1'b0;
    logic        o_iss_ready;
    logic [4:0]  i_iss_rd = '0;
    logic [31:0] o_busy;
    logic        o_we;
    logic [4:0]  o_wr_address;
    logic [31:0] o_wr_data;
    logic        o_ld_err;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
        .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
        .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
        .i_ld_funct3(i_ld_funct3), .i_ld_off(i_ld_off),
        .i_iss_valid(i_iss_valid), .o_iss_ready(o_iss_ready), .i_iss_rd(i_iss_rd),
        .o_busy(o_busy), .o_we(o_we), .o_wr_address(o_wr_address),
        .o_wr_data(o_wr_data), .o_ld_err(o_ld_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_alu_valid = 1'b0;
        i_ld_valid  = 1'b0;
        i_iss_valid = 1'b0;
    endtask

    // Load extension from the ISA definition using plain integer arithmetic.
    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            3'd2:    return w;
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        i_alu_valid = 1'b1; i_ld_valid = 1'b1; i_iss_valid = 1'b1;
        i_alu_rd = 5'd5; i_ld_rd = 5'd6; i_iss_rd = 5'd7;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if ({o_alu_ready, o_ld_ready, o_iss_ready} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_ready: got %b want 000", {o_alu_ready, o_ld_ready, o_iss_ready});
            end
            tick();
        end
        idle();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({o_we, o_wr_address, o_wr_data, o_ld_err, o_busy} !== 71'd0) begin
            n_fail++;
            $display("FAIL reset_state: we=%b addr=%0d data=%h err=%b busy=%h, want all 0",
                     o_we, o_wr_address, o_wr_data, o_ld_err, o_busy);
        end
        n_cmp++;
        if ({o_alu_ready, o_ld_ready, o_iss_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL post_reset_ready: got %b want 111", {o_alu_ready, o_ld_ready, o_iss_ready});
        end
    endtask

    task automatic test_alu();
        i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'hDEAD_BEEF;
        tick();
        idle();
        n_cmp++;
        if ({o_we, o_wr_address, o_wr_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL alu_write: got we=%b addr=%0d data=%h want 1/5/deadbeef", o_we, o_wr_address, o_wr_data);
        end
        tick();
        n_cmp++;
        if (o_we !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_we_pulse: got we=%b want 0", o_we);
        end
        i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'h1234_5678;
        tick();
        idle();
        n_cmp++;
        if ({o_we, o_wr_address, o_wr_data} !== {1'b0, 5'd0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL alu_x0: got we=%b addr=%0d data=%h want 0/0/12345678", o_we, o_wr_address, o_wr_data);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [10] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd3, 3'd0, 3'd0, 3'd1, 3'd7};
        logic [1:0]  offs[10] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd1, 2'd2};
        logic [31:0] exps[10] = '{32'hFFFF_FF82, 32'h0000_0082, 32'hFFFF_80F1, 32'h0000_80F1,
                                  32'h80F1_7F82, 32'h0, 32'h0000_007F, 32'hFFFF_FF80,
                                  32'h0000_7F82, 32'h0};
        logic        errs[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        for (int k = 0; k < 10; k++) begin
            i_ld_valid = 1'b1; i_ld_rd = 5'd9; i_ld_data = 32'h80F1_7F82;
            i_ld_funct3 = f3s[k]; i_ld_off = offs[k];
            tick();
            idle();
            n_cmp++;
            if ({o_we, o_wr_address, o_wr_data, o_ld_err} !== {1'b1, 5'd9, exps[k], errs[k]}) begin
                n_fail++;
                $display("FAIL load_ext[%0d] f3=%0d off=%0d: got we=%b addr=%0d data=%h err=%b want 1/9/%h/%b",
                         k, f3s[k], offs[k], o_we, o_wr_address, o_wr_data, o_ld_err, exps[k], errs[k]);
            end
            tick();
            n_cmp++;
            if ({o_we, o_ld_err} !== 2'b00) begin
                n_fail++;
                $display("FAIL load_pulse[%0d]: got we=%b err=%b want 0/0", k, o_we, o_ld_err);
            end
        end
    endtask

    task automatic test_scoreboard();
        i_iss_valid = 1'b1; i_iss_rd = 5'd7;
        #1;
        n_cmp++;
        if (o_iss_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL iss_ready_free: got %b want 1", o_iss_ready);
        end
        tick();
        n_cmp++;
        if (o_busy !== 32'h80) begin
            n_fail++;
            $display("FAIL busy_set: got %h want 00000080", o_busy);
        end
        #1;
        n_cmp++;
        if (o_iss_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL iss_ready_busy: got %b want 0", o_iss_ready);
        end
        tick();
        idle();
        i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 32'hA5A5_0007;
        #1;
        n_cmp++;
        if ({o_busy, o_alu_ready} !== {32'h80, 1'b0}) begin
            n_fail++;
            $display("FAIL waw_stall: got busy=%h alu_ready=%b want 00000080/0", o_busy, o_alu_ready);
        end
        tick();
        n_cmp++;
        if (o_we !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_no_write: got we=%b want 0", o_we);
        end
        i_ld_valid = 1'b1; i_ld_rd = 5'd7; i_ld_data = 32'h1111_2222; i_ld_funct3 = 3'd2; i_ld_off = 2'd0;
        tick();
        i_ld_valid = 1'b0;
        n_cmp++;
        if ({o_we, o_wr_address, o_wr_data, o_busy} !== {1'b1, 5'd7, 32'h1111_2222, 32'h0}) begin
            n_fail++;
            $display("FAIL load_clears_busy: got we=%b addr=%0d data=%h busy=%h want 1/7/11112222/0",
                     o_we, o_wr_address, o_wr_data, o_busy);
        end
        tick();
        idle();
        n_cmp++;
        if ({o_we, o_wr_address, o_wr_data} !== {1'b1, 5'd7, 32'hA5A5_0007}) begin
            n_fail++;
            $display("FAIL stalled_alu_follows: got we=%b addr=%0d data=%h want 1/7/a5a50007",
                     o_we, o_wr_address, o_wr_data);
        end
        tick();
    endtask

    task automatic test_conflict();
        i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h0000_AAAA;
        i_ld_valid = 1'b1; i_ld_rd = 5'd4; i_ld_data = 32'h0000_BBBB; i_ld_funct3 = 3'd2; i_ld_off = 2'd0;
        #1;
        n_cmp++;
        if ({o_ld_ready, o_alu_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL conflict_ready: got ld/alu=%b want 10", {o_ld_ready, o_alu_ready});
        end
        tick();
        i_ld_valid = 1'b0;
        n_cmp++;
        if ({o_we, o_wr_address, o_wr_data} !== {1'b1, 5'd4, 32'h0000_BBBB}) begin
            n_fail++;
            $display("FAIL conflict_load_first: got we=%b addr=%0d data=%h want 1/4/0000bbbb",
                     o_we, o_wr_address, o_wr_data);
        end
        tick();
        idle();
        n_cmp++;
        if ({o_we, o_wr_address, o_wr_data} !== {1'b1, 5'd3, 32'h0000_AAAA}) begin
            n_fail++;
            $display("FAIL conflict_alu_second: got we=%b addr=%0d data=%h want 1/3/0000aaaa",
                     o_we, o_wr_address, o_wr_data);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        i_iss_valid = 1'b1; i_iss_rd = 5'd7;
        tick();
        idle();
        i_ld_valid = 1'b1; i_ld_rd = 5'd7; i_ld_data = 32'h5555_6666; i_ld_funct3 = 3'd2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_busy, o_ld_ready} !== {32'h80, 1'b0}) begin
            n_fail++;
            $display("FAIL midflight_pre: got busy=%h ld_ready=%b want 00000080/0", o_busy, o_ld_ready);
        end
        tick();
        idle();
        rst = 1'b0;
        n_cmp++;
        if ({o_we, o_busy, o_wr_data} !== 65'd0) begin
            n_fail++;
            $display("FAIL midflight_reset: got we=%b busy=%h data=%h want 0/0/0", o_we, o_busy, o_wr_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_busy;
        logic        m_we, m_err, e_alu, e_iss, ld_x, alu_x;
        logic [4:0]  m_addr;
        logic [31:0] m_data;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        m_busy = 0; m_we = 0; m_err = 0; m_addr = 0; m_data = 0;
        for (int c = 0; c < 400; c++) begin
            i_alu_valid = 1'($urandom_range(0, 1));
            i_alu_rd    = 5'($urandom_range(0, 7));
            i_alu_data  = $urandom;
            i_ld_valid  = ($urandom_range(0, 2) == 0);
            i_ld_rd     = 5'($urandom_range(0, 7));
            i_ld_data   = $urandom;
            i_ld_funct3 = 3'($urandom_range(0, 7));
            i_ld_off    = 2'($urandom_range(0, 3));
            i_iss_valid = 1'($urandom_range(0, 1));
            i_iss_rd    = 5'($urandom_range(0, 7));
            #1;
            e_alu = !i_ld_valid && !(m_busy[i_alu_rd] && i_alu_rd != 0);
            e_iss = (i_iss_rd == 0) || !m_busy[i_iss_rd];
            n_cmp++;
            if ({o_ld_ready, o_alu_ready, o_iss_ready} !== {1'b1, e_alu, e_iss}) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got ld/alu/iss=%b want %b", c,
                         {o_ld_ready, o_alu_ready, o_iss_ready}, {1'b1, e_alu, e_iss});
            end
            ld_x  = i_ld_valid;
            alu_x = i_alu_valid && e_alu;
            m_we = 0; m_err = 0;
            if (ld_x) begin
                m_we   = (i_ld_rd != 0);
                m_addr = i_ld_rd;
                m_data = ext_model(i_ld_funct3, i_ld_off, i_ld_data);
                m_err  = !(i_ld_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                m_busy[i_ld_rd] = 1'b0;
            end else if (alu_x) begin
                m_we   = (i_alu_rd != 0);
                m_addr = i_alu_rd;
                m_data = i_alu_data;
            end
            if (i_iss_valid && e_iss && i_iss_rd != 0)
                m_busy[i_iss_rd] = 1'b1;
            tick();
            n_cmp++;
            if ({o_we, o_wr_address, o_wr_data, o_ld_err, o_busy} !== {m_we, m_addr, m_data, m_err, m_busy}) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got we=%b addr=%0d data=%h err=%b busy=%h want %b/%0d/%h/%b/%h",
                         c, o_we, o_wr_address, o_wr_data, o_ld_err, o_busy,
                         m_we, m_addr, m_data, m_err, m_busy);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_scoreboard();
        test_conflict();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
